// File: rtl/bypass_meta_arbiter_mq.sv
// bypass_meta_arbiter_mq: round-robin SQ merge and vfid demux of RQ RD/WR with drop counting; optional grant stats via BYPASS_META_STATS_EN
module bypass_meta_fifo #(
  parameter int W = 96,
  parameter int D = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(D);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  // storage write, no reset needed since occupancy gates visibility
  always_ff @(posedge aclk)
    if (do_push) mem[wp] <= din;
  // pointers and occupancy
  always_ff @(posedge aclk)
    if (!aresetn) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

module bypass_meta_arbiter_mq #(
  parameter int N_CH = 4,
  parameter int DATA_W = 96,
  parameter int VFID_LSB = 0,
  parameter int VFID_W = 4,
  parameter int RD_HOST_BIT = 8,
  parameter int QDEPTH = 8,
  parameter int PORT_BYPASS_RX = 10,
  parameter int PORT_BYPASS_TX = 11
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_CH-1:0]          s_sq_valid,
  output logic [N_CH-1:0]          s_sq_ready,
  input  logic [N_CH*DATA_W-1:0]   s_sq_data,
  output logic                     m_sq_valid,
  input  logic                     m_sq_ready,
  output logic [DATA_W-1:0]        m_sq_data,
  input  logic                     s_rd_valid,
  output logic                     s_rd_ready,
  input  logic [DATA_W-1:0]        s_rd_data,
  output logic [N_CH-1:0]          m_rd_valid,
  input  logic [N_CH-1:0]          m_rd_ready,
  output logic [N_CH*DATA_W-1:0]   m_rd_data,
  input  logic                     s_wr_valid,
  output logic                     s_wr_ready,
  input  logic [DATA_W-1:0]        s_wr_data,
  output logic [N_CH-1:0]          m_wr_valid,
  input  logic [N_CH-1:0]          m_wr_ready,
  output logic [N_CH*DATA_W-1:0]   m_wr_data,
  output logic [13:0]              route_id_tx,
  output logic                     route_id_tx_valid,
  output logic [13:0]              route_id_rx,
  output logic                     route_id_rx_valid,
  output logic [15:0]              drop_cnt,
  output logic [N_CH*32-1:0]       stat_sq_grants
);
  localparam int GW = N_CH > 1 ? $clog2(N_CH) : 1;
  logic [N_CH-1:0] sq_full, sq_empty, sq_pop, rd_full, rd_empty, rd_push, wr_full, wr_empty, wr_push;
  logic [DATA_W-1:0] sq_head [N_CH];
  logic [GW-1:0] rr_ptr, grant;
  logic any, load;
  logic [VFID_W-1:0] rd_vfid, wr_vfid;
  logic rd_legal, wr_legal, rd_sel_full, wr_sel_full, rd_drop, wr_drop;
  logic [16:0] drop_sum;
  int idx;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    bypass_meta_fifo #(.W(DATA_W), .D(QDEPTH)) u_sq (
      .aclk(aclk), .aresetn(aresetn), .push(s_sq_valid[i]), .din(s_sq_data[i*DATA_W +: DATA_W]),
      .pop(sq_pop[i]), .full(sq_full[i]), .empty(sq_empty[i]), .dout(sq_head[i])
    );
    bypass_meta_fifo #(.W(DATA_W), .D(QDEPTH)) u_rd (
      .aclk(aclk), .aresetn(aresetn), .push(rd_push[i]), .din(s_rd_data),
      .pop(m_rd_ready[i]), .full(rd_full[i]), .empty(rd_empty[i]), .dout(m_rd_data[i*DATA_W +: DATA_W])
    );
    bypass_meta_fifo #(.W(DATA_W), .D(QDEPTH)) u_wr (
      .aclk(aclk), .aresetn(aresetn), .push(wr_push[i]), .din(s_wr_data),
      .pop(m_wr_ready[i]), .full(wr_full[i]), .empty(wr_empty[i]), .dout(m_wr_data[i*DATA_W +: DATA_W])
    );
    assign s_sq_ready[i] = !sq_full[i];
    assign sq_pop[i] = load && any && grant == GW'(i);
    assign m_rd_valid[i] = !rd_empty[i];
    assign m_wr_valid[i] = !wr_empty[i];
    assign rd_push[i] = s_rd_valid && rd_legal && int'(rd_vfid) == i;
    assign wr_push[i] = s_wr_valid && wr_legal && int'(wr_vfid) == i;
  end

  assign load = !m_sq_valid || m_sq_ready;

  // round-robin pick: lowest offset from rr_ptr with a non-empty FIFO wins
  always_comb begin
    grant = '0;
    any = 1'b0;
    idx = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k >= N_CH ? int'(rr_ptr) + k - N_CH : int'(rr_ptr) + k;
      if (!sq_empty[idx]) begin
        grant = GW'(idx);
        any = 1'b1;
      end
    end
  end

  // SQ output register, rotation pointer and tx route travel together on each load
  always_ff @(posedge aclk)
    if (!aresetn) begin
      m_sq_valid <= 1'b0;
      m_sq_data <= '0;
      rr_ptr <= '0;
      route_id_tx <= '0;
      route_id_tx_valid <= 1'b0;
    end else if (load) begin
      m_sq_valid <= any;
      if (any) begin
        m_sq_data <= sq_head[grant];
        rr_ptr <= int'(grant) + 1 == N_CH ? '0 : grant + 1'b1;
        route_id_tx <= {4'b0, 4'(grant), 4'(PORT_BYPASS_TX), 2'b0};
        route_id_tx_valid <= 1'b1;
      end
    end

  assign rd_vfid = s_rd_data[VFID_LSB +: VFID_W];
  assign wr_vfid = s_wr_data[VFID_LSB +: VFID_W];
  assign rd_legal = int'(rd_vfid) < N_CH && s_rd_data[RD_HOST_BIT];
  assign wr_legal = int'(wr_vfid) < N_CH;

  // fullness of the FIFO each command is addressed to
  always_comb begin
    rd_sel_full = 1'b0;
    wr_sel_full = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      rd_sel_full = int'(rd_vfid) == k ? rd_full[k] : rd_sel_full;
      wr_sel_full = int'(wr_vfid) == k ? wr_full[k] : wr_sel_full;
    end
  end

  assign s_rd_ready = rd_legal ? !rd_sel_full : 1'b1;
  assign s_wr_ready = wr_legal ? !wr_sel_full : 1'b1;
  assign rd_drop = s_rd_valid && !rd_legal;
  assign wr_drop = s_wr_valid && !wr_legal;
  assign drop_sum = {1'b0, drop_cnt} + 17'(rd_drop) + 17'(wr_drop);

  // rx route follows the last accepted legal WR; drops saturate
  always_ff @(posedge aclk)
    if (!aresetn) begin
      drop_cnt <= '0;
      route_id_rx <= '0;
      route_id_rx_valid <= 1'b0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (s_wr_valid && wr_legal && !wr_sel_full) begin
        route_id_rx <= {4'b0, 4'(PORT_BYPASS_RX), 4'(wr_vfid), 2'b0};
        route_id_rx_valid <= 1'b1;
      end
    end

`ifdef BYPASS_META_STATS_EN
  for (genvar i = 0; i < N_CH; i++) begin : g_stat
    // per-region grant counter, wraps at 2^32
    always_ff @(posedge aclk)
      if (!aresetn) stat_sq_grants[i*32 +: 32] <= '0;
      else if (sq_pop[i]) stat_sq_grants[i*32 +: 32] <= stat_sq_grants[i*32 +: 32] + 32'd1;
  end
`else
  assign stat_sq_grants = '0;
`endif
endmodule

// File: tb/tb_bypass_meta_arbiter_mq.sv
// tb_bypass_meta_arbiter_mq: directed bench for the bypass metadata arbiter
module tb_bypass_meta_arbiter_mq;
  logic aclk = 1'b0;
  logic aresetn;
  logic [3:0] s_sq_valid, s_sq_ready;
  logic [383:0] s_sq_data;
  logic m_sq_valid, m_sq_ready;
  logic [95:0] m_sq_data;
  logic s_rd_valid, s_rd_ready;
  logic [95:0] s_rd_data;
  logic [3:0] m_rd_valid, m_rd_ready;
  logic [383:0] m_rd_data;
  logic s_wr_valid, s_wr_ready;
  logic [95:0] s_wr_data;
  logic [3:0] m_wr_valid, m_wr_ready;
  logic [383:0] m_wr_data;
  logic [13:0] route_id_tx, route_id_rx;
  logic route_id_tx_valid, route_id_rx_valid;
  logic [15:0] drop_cnt;
  logic [127:0] stat_sq_grants;
  logic [31:0] exp_g;
  int n_checks = 0;
  int n_err = 0;

  bypass_meta_arbiter_mq dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
    .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready), .m_sq_data(m_sq_data),
    .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready), .s_rd_data(s_rd_data),
    .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_data(m_rd_data),
    .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_wr_data(s_wr_data),
    .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready), .m_wr_data(m_wr_data),
    .route_id_tx(route_id_tx), .route_id_tx_valid(route_id_tx_valid),
    .route_id_rx(route_id_rx), .route_id_rx_valid(route_id_rx_valid),
    .drop_cnt(drop_cnt), .stat_sq_grants(stat_sq_grants)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    s_sq_valid = '0; s_sq_data = '0; m_sq_ready = 1'b0;
    s_rd_valid = 1'b0; s_rd_data = '0; m_rd_ready = '0;
    s_wr_valid = 1'b0; s_wr_data = '0; m_wr_ready = '0;
  endtask

  initial begin
    idle();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_sq_ready", s_sq_ready, 4'hF);
    chk("rst_rd_ready", s_rd_ready, 1);
    chk("rst_wr_ready", s_wr_ready, 1);
    chk("rst_m_sq_valid", m_sq_valid, 0);
    chk("rst_m_rd_valid", m_rd_valid, 0);
    chk("rst_m_wr_valid", m_wr_valid, 0);
    chk("rst_tx_valid", route_id_tx_valid, 0);
    chk("rst_rx_valid", route_id_rx_valid, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_route_tx", route_id_tx, 0);

    for (int k = 0; k < 3; k++) begin
      s_sq_valid = 4'hF;
      for (int i = 0; i < 4; i++) s_sq_data[i*96 +: 96] = 96'(i*16 + k);
      @(negedge aclk);
    end
    s_sq_valid = '0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", m_sq_valid, 1);
      chk("stall_data", m_sq_data, 0);
      chk("stall_route", route_id_tx, 14'h02C);
      @(negedge aclk);
    end
    m_sq_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      chk("rr_valid", m_sq_valid, 1);
      chk("rr_data", m_sq_data, 96'((j % 4)*16 + j/4));
      chk("rr_route", route_id_tx[9:6], j % 4);
      @(negedge aclk);
    end
    chk("rr_drained", m_sq_valid, 0);

    s_sq_valid = 4'b0100; s_sq_data[2*96 +: 96] = 96'hA1;
    @(negedge aclk);
    s_sq_data[2*96 +: 96] = 96'hB2;
    @(negedge aclk);
    chk("join_a", m_sq_data, 96'hA1);
    chk("join_a_route", route_id_tx[9:6], 2);
    s_sq_valid = 4'b0101; s_sq_data[0 +: 96] = 96'hD0; s_sq_data[2*96 +: 96] = 96'hC3;
    @(negedge aclk);
    s_sq_valid = '0;
    chk("join_b", m_sq_data, 96'hB2);
    @(negedge aclk);
    chk("join_r0", m_sq_data, 96'hD0);
    chk("join_r0_route", route_id_tx[9:6], 0);
    @(negedge aclk);
    chk("join_c", m_sq_data, 96'hC3);
    chk("join_c_route", route_id_tx[9:6], 2);
    @(negedge aclk);
    chk("join_done", m_sq_valid, 0);

    s_wr_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      s_wr_data = 96'(k*256 + 3);
      #1 chk("wr_fill_ready", s_wr_ready, k < 8);
      @(negedge aclk);
    end
    s_wr_valid = 1'b0;
    chk("wr_valid", m_wr_valid, 4'b1000);
    chk("wr_head", m_wr_data[3*96 +: 96], 96'h3);
    chk("wr_route_rx", route_id_rx, 14'h28C);
    chk("wr_rx_valid", route_id_rx_valid, 1);
    chk("wr_no_drop", drop_cnt, 0);
    m_wr_ready = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      chk("wr_drain", m_wr_data[3*96 +: 96], 96'(k*256 + 3));
      @(negedge aclk);
    end
    chk("wr_empty", m_wr_valid, 0);
    m_wr_ready = '0;

    s_rd_valid = 1'b1; s_rd_data = 96'h105;
    s_wr_valid = 1'b1; s_wr_data = 96'h7;
    #1 chk("drop_rd_ready", s_rd_ready, 1);
    chk("drop_wr_ready", s_wr_ready, 1);
    @(negedge aclk);
    chk("drop_two", drop_cnt, 2);
    s_wr_valid = 1'b0; s_rd_data = 96'h001;
    #1 chk("drop_host_ready", s_rd_ready, 1);
    @(negedge aclk);
    s_rd_valid = 1'b0;
    chk("drop_three", drop_cnt, 3);
    chk("drop_no_rd", m_rd_valid, 0);
    chk("drop_no_wr", m_wr_valid, 0);
    chk("drop_rx_kept", route_id_rx, 14'h28C);
    s_rd_valid = 1'b1; s_rd_data = 96'hABC101;
    @(negedge aclk);
    s_rd_valid = 1'b0;
    chk("rd_legal_valid", m_rd_valid, 4'b0010);
    chk("rd_legal_data", m_rd_data[96 +: 96], 96'hABC101);
    chk("rd_legal_drop", drop_cnt, 3);

    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst2_rd_valid", m_rd_valid, 0);
    chk("rst2_drop", drop_cnt, 0);
    chk("rst2_rx", route_id_rx, 0);
    chk("rst2_tx", route_id_tx, 0);

    m_sq_ready = 1'b1;
    s_sq_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      s_sq_data[96 +: 96] = 96'(k);
      @(negedge aclk);
    end
    s_sq_valid = '0;
    repeat (4) @(negedge aclk);
`ifdef BYPASS_META_STATS_EN
    exp_g = 32'd10;
`else
    exp_g = 32'd0;
`endif
    chk("stat_r1", stat_sq_grants[63:32], exp_g);
    chk("stat_r0", stat_sq_grants[31:0], 0);
    chk("stat_tx_route", route_id_tx[9:6], 1);

    m_sq_ready = 1'b0;
    s_sq_valid = 4'b1000; s_sq_data[3*96 +: 96] = 96'h55;
    s_wr_valid = 1'b1; s_wr_data = 96'h2;
    repeat (2) @(negedge aclk);
    chk("burst_valid", m_sq_valid, 1);
    chk("burst_rx_valid", route_id_rx_valid, 1);
    aresetn = 1'b0;
    idle();
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("flush_sq_valid", m_sq_valid, 0);
    chk("flush_wr_valid", m_wr_valid, 0);
    chk("flush_tx", route_id_tx, 0);
    chk("flush_tx_valid", route_id_tx_valid, 0);
    chk("flush_rx", route_id_rx, 0);
    chk("flush_rx_valid", route_id_rx_valid, 0);
    chk("flush_stats", stat_sq_grants, 0);
    m_sq_ready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("flush_no_emit", m_sq_valid, 0);
    chk("flush_no_wr", m_wr_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/bypass_meta_arbiter_mq.md
Name: bypass_meta_arbiter_mq

Overview:
Parametrised next-generation metadata arbiter between the bypass network stack and N_CH user regions. It buffers each SQ channel and merges them onto the network with true round-robin fairness. It also demultiplexes RQ RD and RQ WR commands by vfid into per-region FIFOs, dropping and counting commands with an illegal destination. Route IDs for the vIO Switch tdest are registered, qualified with a valid flag and updated only on accepted handshakes; data never passes through this block.

Parameters:
N_CH, 4, number of user regions (1..16)
DATA_W, 96, metadata word width (SQ and RQ)
VFID_LSB, 0, bit offset of the vfid field inside RQ data
VFID_W, 4, vfid field width (≤4)
RD_HOST_BIT, 8, RQ RD host-flag bit position; RD with host=0 is dropped
QDEPTH, 8, entries per FIFO (power of 2, ≥2)
PORT_BYPASS_RX, 10, 4-bit vIO Switch sender id for RX routes
PORT_BYPASS_TX, 11, 4-bit vIO Switch receiver id for TX routes

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
s_sq_valid  in  N_CH  per-region SQ valid
s_sq_ready  out  N_CH  per-region SQ ready
s_sq_data  in  N_CH*DATA_W  per-region SQ data, region i at [i*DATA_W +: DATA_W]
m_sq_valid / m_sq_ready / m_sq_data  out/in/out  1/1/DATA_W  SQ to network
s_rd_valid / s_rd_ready / s_rd_data  in/out/in  1/1/DATA_W  RD commands from network
m_rd_valid / m_rd_ready / m_rd_data  out/in/out  N_CH/N_CH/N_CH*DATA_W  RD commands to regions
s_wr_valid / s_wr_ready / s_wr_data  in/out/in  1/1/DATA_W  WR commands from network
m_wr_valid / m_wr_ready / m_wr_data  out/in/out  N_CH/N_CH/N_CH*DATA_W  WR commands to regions
route_id_tx  out  14  {4'b0, src_region[3:0], PORT_BYPASS_TX, 2'b0}
route_id_tx_valid  out  1  set on first SQ grant, sticky
route_id_rx  out  14  {4'b0, PORT_BYPASS_RX, vfid[3:0], 2'b0}
route_id_rx_valid  out  1  set on first accepted WR, sticky
drop_cnt  out  16  saturating count of dropped RD/WR commands
stat_sq_grants  out  N_CH*32  per-region grant counters (optional feature)

Behaviour:
- Reset: all FIFOs empty; all m_*_valid=0; s_*_ready reflects empty FIFOs (1) from the first cycle after reset; rr_ptr=0; route_id_*=0; *_valid flags=0; drop_cnt=0; stats=0. A mid-operation reset flushes all in-flight entries without emitting them.
- FIFOs: registered with ready = !full and no full-state pass-through. Push and pop in the same cycle on a full FIFO: pop only, ready stays 0 that cycle. Push on empty: head visible the next cycle.
- SQ path: per-region FIFO, followed by an output register driving m_sq_*.
- Output register loads when empty or when (m_sq_valid && m_sq_ready).
- Grant goes to the first non-empty FIFO scanning rr_ptr, rr_ptr+1, … mod N_CH.
- On load: rr_ptr <= (grant+1) mod N_CH, and route_id_tx updates with grant on the same edge.
- Minimum latency s_sq handshake → m_sq_valid: 2 cycles. Sustained 1 word/cycle when m_sq_ready=1.
- m_sq_data and route_id_tx are stable while m_sq_valid && !m_sq_ready.
- RD demux: vfid = data[VFID_LSB +: VFID_W].
  - Legal if vfid < N_CH and data[RD_HOST_BIT]=1.
  - Legal: s_rd_ready = !full[vfid]; push on handshake.
  - Illegal: s_rd_ready=1; the command is consumed and drop_cnt increments.
- WR demux: same as RD without the host check.
  - Each accepted legal WR registers route_id_rx with its vfid and sets route_id_rx_valid.
  - Dropped WRs leave route_id_rx unchanged.
- drop_cnt: RD and WR drops in the same cycle add 2; saturates at 16'hFFFF.
- m_rd/m_wr per region: valid = !empty, data = FIFO head.
- N_CH=1: arbitration is degenerate, grant always 0; behaviour is otherwise identical.

Optional Feature:
BYPASS_META_STATS_EN
- Defined: stat_sq_grants[i] is a 32-bit counter incremented on each output-register load granted to region i; it wraps at 2^32 and resets to 0.
- Undefined: no counters are instantiated and stat_sq_grants is tied to 0.

Test Plan:
- Reset release with all inputs idle → s_*_ready all 1, m_*_valid all 0, route_id_tx_valid=0, route_id_rx_valid=0, drop_cnt=0.
- N_CH=4, all four SQ FIFOs preloaded with 3 words, m_sq_ready=1 → grant order 0,1,2,3,0,1,2,3,… and route_id_tx[9:6] follows that order.
- Only region 2 is active, then region 0 joins mid-stream → region 0 is served within 1 grant.
- m_sq_ready=0 for 5 cycles with valid pending → m_sq_data and route_id_tx are constant.
- WR with vfid=3, m_wr_ready[3]=0, QDEPTH=8, 9 commands → 8 accepted, then s_wr_ready=0; route_id_rx={4'b0,4'd10,4'd3,2'b0} and route_id_rx_valid=1.
- RD with vfid=5 (N_CH=4) and RD with host=0, simultaneous with a WR with vfid=7 → drop_cnt=3; no m_rd/m_wr valid; route_id_rx unchanged.
- With BYPASS_META_STATS_EN, 10 grants to region 1 → stat_sq_grants[63:32]=10; assert reset mid-burst → counters, FIFOs and route IDs all return to 0.
